// File: rtl/axi_node_pkg.sv
// ---------------------------------------------------------------------------
// axi_node_pkg
// Shared types and constants for the AXI node read-address path.
//   ar_dec_state_e  : state encoding of the AR decoder FSM
//   AXI_LEN_W       : AXI burst-length field width
//   ar_rule_t       : one address-rule table entry (start, end, valid)
//   rule_hit()      : inclusive unsigned range test of one rule
// ---------------------------------------------------------------------------
package axi_node_pkg;

    localparam int unsigned AXI_LEN_W       = 8;
    // Rule addresses are held zero-extended to this width so one struct type
    // serves every address width up to 64 bits.
    localparam int unsigned AXI_RULE_ADDR_W = 64;

    typedef enum logic [1:0] {
        OPERATIVE,
        ERROR_REQ,
        ERROR_WAIT
    } ar_dec_state_e;

    typedef struct packed {
        logic [AXI_RULE_ADDR_W-1:0] start_addr;
        logic [AXI_RULE_ADDR_W-1:0] end_addr;
        logic                       valid;
    } ar_rule_t;

    function automatic logic rule_hit(input ar_rule_t rule,
                                      input logic [AXI_RULE_ADDR_W-1:0] addr);
        return rule.valid && (addr >= rule.start_addr) && (addr <= rule.end_addr);
    endfunction

endpackage

// File: rtl/axi_ar_addr_match.sv
// ---------------------------------------------------------------------------
// axi_ar_addr_match
// Combinational address decode against the region rule table followed by a
// lowest-index priority encode over the initiator hits.
// Ports:
//   addr_i        : address to decode
//   start_addr_i  : flat rule starts, entry [r][k] at ((r*N_INIT_PORT)+k)*AXI_ADDR_W
//   end_addr_i    : flat rule ends, same layout
//   valid_rule_i  : rule enables, entry [r][k] at bit (r*N_INIT_PORT)+k
//   match_valid   : at least one initiator hit
//   match_idx     : lowest hitting initiator index (0 when no hit)
// ---------------------------------------------------------------------------
module axi_ar_addr_match
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT = 4,
    parameter int N_REGION    = 2,
    parameter int AXI_ADDR_W  = 32,
    parameter int LOG_N_INIT  = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
    input  logic [AXI_ADDR_W-1:0]                      addr_i,
    input  logic [N_REGION*N_INIT_PORT*AXI_ADDR_W-1:0] start_addr_i,
    input  logic [N_REGION*N_INIT_PORT*AXI_ADDR_W-1:0] end_addr_i,
    input  logic [N_REGION*N_INIT_PORT-1:0]            valid_rule_i,
    output logic                                       match_valid,
    output logic [LOG_N_INIT-1:0]                      match_idx
);

    logic [N_INIT_PORT-1:0] hit;
    ar_rule_t               rule;

    always_comb begin
        hit  = '0;
        rule = '0;
        for (int unsigned k = 0; k < N_INIT_PORT; k++) begin
            for (int unsigned r = 0; r < N_REGION; r++) begin
                rule.start_addr = AXI_RULE_ADDR_W'(start_addr_i[(r*N_INIT_PORT+k)*AXI_ADDR_W +: AXI_ADDR_W]);
                rule.end_addr   = AXI_RULE_ADDR_W'(end_addr_i[(r*N_INIT_PORT+k)*AXI_ADDR_W +: AXI_ADDR_W]);
                rule.valid      = valid_rule_i[r*N_INIT_PORT+k];
                if (rule_hit(rule, AXI_RULE_ADDR_W'(addr_i))) begin
                    hit[k] = 1'b1;
                end
            end
        end
    end

    // First hit scanning upward wins.
    always_comb begin
        match_valid = 1'b0;
        match_idx   = '0;
        for (int unsigned k = 0; k < N_INIT_PORT; k++) begin
            if (hit[k] && !match_valid) begin
                match_valid = 1'b1;
                match_idx   = LOG_N_INIT'(k);
            end
        end
    end

endmodule

// File: rtl/axi_ar_decoder.sv
// ---------------------------------------------------------------------------
// axi_ar_decoder
// Read-address decoder for one target port of the AXI node. Routes each AR
// to the single initiator whose rule matches (lowest index on overlap), or
// consumes misses locally and raises an error-response request carrying the
// AR id/user/len until the allocator grants it.
// Optional feature macro: AXI_AR_DEST_LOCK_EN -- when defined, a hit to a
// different initiator than the last routed one stalls while routed reads are
// outstanding.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   araddr_i/arid_i/arlen_i/aruser_i/arvalid_i, arready_o : AR from master
//   arvalid_o, arready_i     : one-hot AR valid / ready per initiator
//   start_addr_i/end_addr_i/valid_rule_i : region rule table
//   incr_req_o               : pulse per accepted routed AR
//   full_counter_i           : allocator outstanding counter saturated
//   outstanding_trans_i      : allocator has routed reads pending
//   error_req_o, error_gnt_i : error response request / completion
//   error_len_o/error_user_o/error_id_o : captured miss descriptor
//   sample_ardata_info_o     : descriptor capture strobe for the allocator
// ---------------------------------------------------------------------------
module axi_ar_decoder
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT = 4,
    parameter int N_REGION    = 2,
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_ID_IN   = 16,
    parameter int AXI_USER_W  = 6,
    parameter int LOG_N_INIT  = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [AXI_ADDR_W-1:0]                      araddr_i,
    input  logic [AXI_ID_IN-1:0]                       arid_i,
    input  logic [7:0]                                 arlen_i,
    input  logic [AXI_USER_W-1:0]                      aruser_i,
    input  logic                                       arvalid_i,
    output logic                                       arready_o,
    output logic [N_INIT_PORT-1:0]                     arvalid_o,
    input  logic [N_INIT_PORT-1:0]                     arready_i,
    input  logic [N_REGION*N_INIT_PORT*AXI_ADDR_W-1:0] start_addr_i,
    input  logic [N_REGION*N_INIT_PORT*AXI_ADDR_W-1:0] end_addr_i,
    input  logic [N_REGION*N_INIT_PORT-1:0]            valid_rule_i,
    output logic                                       incr_req_o,
    input  logic                                       full_counter_i,
    input  logic                                       outstanding_trans_i,
    output logic                                       error_req_o,
    input  logic                                       error_gnt_i,
    output logic [7:0]                                 error_len_o,
    output logic [AXI_USER_W-1:0]                      error_user_o,
    output logic [AXI_ID_IN-1:0]                       error_id_o,
    output logic                                       sample_ardata_info_o
);

    ar_dec_state_e          state_q, state_d;
    logic [AXI_ID_IN-1:0]   error_id_q, error_id_d;
    logic [AXI_USER_W-1:0]  error_user_q, error_user_d;
    logic [AXI_LEN_W-1:0]   error_len_q, error_len_d;

    logic                   match_valid;
    logic [LOG_N_INIT-1:0]  match_idx;
    logic                   lock_ok;
    logic                   eligible;

    axi_ar_addr_match #(
        .N_INIT_PORT (N_INIT_PORT),
        .N_REGION    (N_REGION),
        .AXI_ADDR_W  (AXI_ADDR_W),
        .LOG_N_INIT  (LOG_N_INIT)
    ) u_addr_match (
        .addr_i       (araddr_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .valid_rule_i (valid_rule_i),
        .match_valid  (match_valid),
        .match_idx    (match_idx)
    );

`ifdef AXI_AR_DEST_LOCK_EN
    logic [LOG_N_INIT-1:0]  last_dest_q, last_dest_d;

    // Switching destination while reads are in flight could reorder responses.
    assign lock_ok = !(outstanding_trans_i && (match_idx != last_dest_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dest_q <= '0;
        end else begin
            last_dest_q <= last_dest_d;
        end
    end
`else
    logic unused_outstanding;

    assign unused_outstanding = outstanding_trans_i;
    assign lock_ok            = 1'b1;
`endif

    // Eligibility uses only request-side inputs, keeping arvalid_o free of arready_i.
    assign eligible = !full_counter_i && lock_ok;

    always_comb begin
        state_d              = state_q;
        error_id_d           = error_id_q;
        error_user_d         = error_user_q;
        error_len_d          = error_len_q;
`ifdef AXI_AR_DEST_LOCK_EN
        last_dest_d          = last_dest_q;
`endif
        arready_o            = 1'b0;
        arvalid_o            = '0;
        incr_req_o           = 1'b0;
        error_req_o          = 1'b0;
        sample_ardata_info_o = 1'b0;

        unique case (state_q)
            OPERATIVE: begin
                if (arvalid_i) begin
                    if (match_valid) begin
                        if (eligible) begin
                            arvalid_o[match_idx] = 1'b1;
                            arready_o            = arready_i[match_idx];
                            if (arready_i[match_idx]) begin
                                incr_req_o = 1'b1;
`ifdef AXI_AR_DEST_LOCK_EN
                                last_dest_d = match_idx;
`endif
                            end
                        end
                    end else begin
                        arready_o    = 1'b1;
                        error_id_d   = arid_i;
                        error_user_d = aruser_i;
                        error_len_d  = arlen_i;
                        state_d      = ERROR_REQ;
                    end
                end
            end
            ERROR_REQ: begin
                error_req_o          = 1'b1;
                sample_ardata_info_o = 1'b1;
                state_d              = error_gnt_i ? OPERATIVE : ERROR_WAIT;
            end
            ERROR_WAIT: begin
                error_req_o = 1'b1;
                if (error_gnt_i) begin
                    state_d = OPERATIVE;
                end
            end
            default: begin
                state_d = OPERATIVE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OPERATIVE;
            error_id_q   <= '0;
            error_user_q <= '0;
            error_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            error_id_q   <= error_id_d;
            error_user_q <= error_user_d;
            error_len_q  <= error_len_d;
        end
    end

    assign error_id_o   = error_id_q;
    assign error_user_o = error_user_q;
    assign error_len_o  = error_len_q;

endmodule

// File: tb/tb_axi_ar_decoder.sv
module tb_axi_ar_decoder;

    localparam int NI  = 4;
    localparam int NR  = 2;
    localparam int AW  = 32;
    localparam int IDW = 16;
    localparam int UW  = 6;
`ifdef AXI_AR_DEST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [AW-1:0]      araddr;
    logic [IDW-1:0]     arid;
    logic [7:0]         arlen;
    logic [UW-1:0]      aruser;
    logic               arvalid;
    logic               arready_o;
    logic [NI-1:0]      arvalid_o;
    logic [NI-1:0]      arready_i;
    logic [NR*NI*AW-1:0] start_flat, end_flat;
    logic [NR*NI-1:0]   valid_flat;
    logic               incr_req;
    logic               full_counter;
    logic               outstanding;
    logic               error_req;
    logic               error_gnt;
    logic [7:0]         error_len;
    logic [UW-1:0]      error_user;
    logic [IDW-1:0]     error_id;
    logic               sample_info;

    always #5 clk = ~clk;

    axi_ar_decoder #(
        .N_INIT_PORT (NI),
        .N_REGION    (NR),
        .AXI_ADDR_W  (AW),
        .AXI_ID_IN   (IDW),
        .AXI_USER_W  (UW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .araddr_i             (araddr),
        .arid_i               (arid),
        .arlen_i              (arlen),
        .aruser_i             (aruser),
        .arvalid_i            (arvalid),
        .arready_o            (arready_o),
        .arvalid_o            (arvalid_o),
        .arready_i            (arready_i),
        .start_addr_i         (start_flat),
        .end_addr_i           (end_flat),
        .valid_rule_i         (valid_flat),
        .incr_req_o           (incr_req),
        .full_counter_i       (full_counter),
        .outstanding_trans_i  (outstanding),
        .error_req_o          (error_req),
        .error_gnt_i          (error_gnt),
        .error_len_o          (error_len),
        .error_user_o         (error_user),
        .error_id_o           (error_id),
        .sample_ardata_info_o (sample_info)
    );

    // Rule table as the bench sees it: [region][initiator].
    logic [AW-1:0] t_start [NR][NI];
    logic [AW-1:0] t_end   [NR][NI];
    logic          t_valid [NR][NI];

    always_comb begin
        start_flat = '0;
        end_flat   = '0;
        valid_flat = '0;
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < NI; k++) begin
                start_flat[(r*NI+k)*AW +: AW] = t_start[r][k];
                end_flat[(r*NI+k)*AW +: AW]   = t_end[r][k];
                valid_flat[r*NI+k]            = t_valid[r][k];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a miss opens an error episode that raises a request
    // from the next cycle until a granted cycle; the first cycle of the
    // episode also strobes the descriptor capture.
    bit             m_in_err;
    bit             m_first;
    int             m_last;
    logic [IDW-1:0] m_id;
    logic [7:0]     m_len;
    logic [UW-1:0]  m_user;
    bit             m_took_hit;
    bit             m_took_miss;
    int             m_dest;

    function automatic int decode(input logic [AW-1:0] a);
        for (int k = 0; k < NI; k++)
            for (int r = 0; r < NR; r++)
                if (t_valid[r][k] && a >= t_start[r][k] && a <= t_end[r][k])
                    return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_in_err = 0; m_first = 0; m_last = 0;
        m_id = '0; m_len = '0; m_user = '0;
    endtask

    // Called at posedge+1 with inputs set; compares at posedge+3.
    task automatic check_cycle();
        logic [NI-1:0] e_vld;
        bit e_rdy, e_incr, ok;
        #2;
        e_vld = '0; e_rdy = 0; e_incr = 0;
        m_took_hit = 0; m_took_miss = 0; m_dest = -1;
        if (!m_in_err && arvalid && !rst) begin
            m_dest = decode(araddr);
            if (m_dest < 0) begin
                e_rdy = 1; m_took_miss = 1;
            end else begin
                ok = !full_counter && !(LOCK_EN && outstanding && m_dest != m_last);
                if (ok) begin
                    e_vld[m_dest] = 1'b1;
                    e_rdy  = arready_i[m_dest];
                    e_incr = arready_i[m_dest];
                    m_took_hit = e_rdy;
                end
            end
        end
        check("arvalid_o", 32'(arvalid_o), 32'(e_vld));
        check("arready_o", 32'(arready_o), 32'(e_rdy));
        check("incr_req_o", 32'(incr_req), 32'(e_incr));
        check("error_req_o", 32'(error_req), 32'(m_in_err));
        check("sample_info", 32'(sample_info), 32'(m_in_err && m_first));
        check("error_id_o", 32'(error_id), 32'(m_id));
        check("error_len_o", 32'(error_len), 32'(m_len));
        check("error_user_o", 32'(error_user), 32'(m_user));
    endtask

    task automatic advance();
        if (rst) begin
            model_reset();
        end else if (m_in_err) begin
            m_first = 0;
            if (error_gnt) m_in_err = 0;
        end else if (m_took_miss) begin
            m_in_err = 1; m_first = 1;
            m_id = arid; m_len = arlen; m_user = aruser;
        end else if (m_took_hit) begin
            m_last = m_dest;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        check_cycle();
        advance();
    endtask

    logic [AW-1:0] dir_addrs [8];

    initial begin
        rst = 1; araddr = '0; arid = '0; arlen = '0; aruser = '0; arvalid = 0;
        arready_i = '0; full_counter = 0; outstanding = 0; error_gnt = 0;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NI; k++) begin
                t_start[r][k] = '0; t_end[r][k] = '0; t_valid[r][k] = 0;
            end
        t_start[0][0] = 32'h0000_0000; t_end[0][0] = 32'h0FFF_FFFF; t_valid[0][0] = 1;
        t_start[0][1] = 32'h1000_0000; t_end[0][1] = 32'h1FFF_FFFF; t_valid[0][1] = 1;
        t_start[0][2] = 32'h2000_0000; t_end[0][2] = 32'h2FFF_FFFF; t_valid[0][2] = 1;
        t_start[0][3] = 32'h2000_0000; t_end[0][3] = 32'h3FFF_FFFF; t_valid[0][3] = 1;
        t_start[1][0] = 32'h5000_0000; t_end[1][0] = 32'h5000_00FF; t_valid[1][0] = 1;
        t_start[1][3] = 32'h6000_0000; t_end[1][3] = 32'h6FFF_FFFF; t_valid[1][3] = 0;
        model_reset();

        @(posedge clk); #1;
        cyc();
        cyc();
        rst = 0;
        cyc();

        // Routed hit to init1.
        araddr = 32'h1000_0004; arvalid = 1; arready_i = 4'b0010;
        check_cycle();
        check("hit_vld_const", 32'(arvalid_o), 32'h2);
        advance();
        arvalid = 0; arready_i = '0;
        cyc();

        // Miss, grant at T+6, hit waits meanwhile.
        araddr = 32'h8000_0000; arid = 16'h003A; arlen = 8'd3; aruser = 6'd5; arvalid = 1;
        cyc();
        araddr = 32'h0000_0100; arready_i = '1; arid = 16'h1111; arlen = 8'd9;
        check_cycle();
        check("miss_len_const", 32'(error_len), 32'd3);
        check("miss_id_const", 32'(error_id), 32'h3A);
        advance();
        for (int i = 2; i <= 5; i++) cyc();
        error_gnt = 1;
        cyc();
        error_gnt = 0;
        check_cycle();
        check("post_grant_incr", 32'(incr_req), 32'd1);
        advance();
        arvalid = 0;

        // Counter saturated then released.
        full_counter = 1; araddr = 32'h0000_0040; arvalid = 1; arready_i = 4'b0001;
        cyc(); cyc();
        full_counter = 0;
        cyc();

        // Lock: last dest is init0, switch to init1 while reads outstanding.
        araddr = 32'h1000_0000; arready_i = 4'b0010; outstanding = 1;
        cyc(); cyc(); cyc();
        outstanding = 0;
        cyc();
        arvalid = 0; arready_i = '0;
        cyc();

        // Overlap and boundaries.
        dir_addrs = '{32'h2000_0000, 32'h2FFF_FFFF, 32'h3000_0000, 32'h3FFF_FFFF,
                      32'h5000_0000, 32'h5000_00FF, 32'h5000_0100, 32'h6000_0000};
        arready_i = '1; error_gnt = 1;
        foreach (dir_addrs[i]) begin
            araddr = dir_addrs[i]; arvalid = 1;
            check_cycle();
            if (i == 0) check("overlap_lowest", 32'(arvalid_o), 32'h4);
            advance();
            arvalid = 0;
            cyc();
        end
        error_gnt = 0;

        // Reset while waiting for the error grant.
        araddr = 32'h9000_0000; arid = 16'h0BEE; arlen = 8'd7; aruser = 6'd2; arvalid = 1;
        cyc();
        arvalid = 0;
        cyc();
        cyc();
        rst = 1;
        #1;
        check("rst_err_req", 32'(error_req), 32'd0);
        check("rst_err_id", 32'(error_id), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        araddr = 32'h1000_0010; arvalid = 1; arready_i = 4'b0010;
        check_cycle();
        check("rst_then_hit", 32'(incr_req), 32'd1);
        advance();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int sel, r, k;
            sel = $urandom_range(0, 4);
            r = $urandom_range(0, NR-1);
            k = $urandom_range(0, NI-1);
            case (sel)
                0: araddr = $urandom;
                1: araddr = t_start[r][k];
                2: araddr = t_end[r][k];
                3: araddr = t_start[r][k] - 1;
                default: araddr = t_end[r][k] + 1;
            endcase
            arvalid      = ($urandom_range(0, 3) != 0);
            arid         = IDW'($urandom);
            arlen        = 8'($urandom);
            aruser       = UW'($urandom);
            arready_i    = NI'($urandom);
            full_counter = ($urandom_range(0, 4) == 0);
            outstanding  = ($urandom_range(0, 1) == 0);
            error_gnt    = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
